// File: rtl/booth_pkg.sv
// Shared widths, FSM state type and Booth-bit encodings for the 4-bit radix-2 Booth multiplier.
package booth_pkg;

  localparam int unsigned OP_W   = 4;
  localparam int unsigned ACC_W  = OP_W + 1;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned REG_W  = ACC_W + OP_W + 1;
  localparam int unsigned PROD_W = 2 * OP_W;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(OP_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // {Q0, Q-1} pairs
  localparam logic [1:0] BOOTH_NOP0 = 2'b00;
  localparam logic [1:0] BOOTH_ADD  = 2'b01;
  localparam logic [1:0] BOOTH_SUB  = 2'b10;
  localparam logic [1:0] BOOTH_NOP1 = 2'b11;

  function automatic logic [ACC_W-1:0] sext_op(input logic [OP_W-1:0] v);
    return {v[OP_W-1], v};
  endfunction

endpackage

// File: rtl/booth_seq_ctrl_if.sv
// Operand/handshake bundle between the Booth controller and its client plus external add/sub mux.
interface booth_seq_ctrl_if;
  import booth_pkg::*;

  logic                i_start;
  logic [OP_W-1:0]     i_mcand;
  logic [OP_W-1:0]     i_mplier;
  logic [ACC_W-1:0]    i_mux_out;
  logic [ACC_W-1:0]    o_acc;
  logic [ACC_W-1:0]    o_mcand_ext;
  logic                o_sub;
  logic                o_mux_sel;
  logic                o_busy;
  logic                o_done;
  logic [PROD_W-1:0]   o_product;

  modport slave (
    input  i_start, i_mcand, i_mplier, i_mux_out,
    output o_acc, o_mcand_ext, o_sub, o_mux_sel, o_busy, o_done, o_product
  );

  modport master (
    output i_start, i_mcand, i_mplier, i_mux_out,
    input  o_acc, o_mcand_ext, o_sub, o_mux_sel, o_busy, o_done, o_product
  );

endinterface

// File: rtl/booth_asr_reg.sv
// A:Q:Q-1 register: parallel load or one-step arithmetic right shift with A replaced by the mux result.
module booth_asr_reg
  import booth_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic [REG_W-1:0] load_val,
  input  logic [ACC_W-1:0] mux_out,
  output logic [REG_W-1:0] aqq
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aqq <= '0;
    end else if (load) begin
      aqq <= load_val;
    end else if (shift) begin
      // drop Q-1, new Q-1 is old Q0, sign of the mux result fills A's MSB
      aqq <= {mux_out[ACC_W-1], mux_out, aqq[OP_W:1]};
    end
  end

endmodule

// File: rtl/booth_seq_ctrl.sv
// Radix-2 Booth sequential controller for the 4-bit signed multiplier.
// Build option BOOTH_ZERO_SKIP_EN: zero operands bypass the iterations and finish one cycle after start.
module booth_seq_ctrl
  import booth_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  booth_seq_ctrl_if.slave   bus
);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [ACC_W-1:0]   mcand_ext;
  logic [PROD_W-1:0]  product;
  logic               busy;
  logic               done;
  logic [REG_W-1:0]   aqq;
  logic [1:0]         booth_bits;
  logic               load;
  logic               shift;
  logic               zero_op;

`ifdef BOOTH_ZERO_SKIP_EN
  assign zero_op = (bus.i_mcand == '0) || (bus.i_mplier == '0);
`else
  assign zero_op = 1'b0;
`endif

  assign load       = (state == IDLE) && bus.i_start;
  assign shift      = (state == CALC);
  assign booth_bits = aqq[1:0];

  booth_asr_reg u_asr_reg (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .load     (load),
    .shift    (shift),
    .load_val ({{ACC_W{1'b0}}, bus.i_mplier, 1'b0}),
    .mux_out  (bus.i_mux_out),
    .aqq      (aqq)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      mcand_ext <= '0;
      product   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (bus.i_start) begin
            mcand_ext <= sext_op(bus.i_mcand);
            cnt       <= '0;
            busy      <= 1'b1;
            if (zero_op) begin
              product <= '0;
              done    <= 1'b1;
              state   <= DONE;
            end else begin
              state   <= CALC;
            end
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST_ITER) begin
            // product taken from the post-shift value: {next A[3:0], next Q}
            product <= {bus.i_mux_out, aqq[OP_W:2]};
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_acc       = aqq[REG_W-1:OP_W+1];
  assign bus.o_mcand_ext = mcand_ext;
  assign bus.o_sub       = (booth_bits == BOOTH_SUB);
  assign bus.o_mux_sel   = (booth_bits == BOOTH_ADD) || (booth_bits == BOOTH_SUB);
  assign bus.o_busy      = busy;
  assign bus.o_done      = done;
  assign bus.o_product   = product;

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Self-checking bench for booth_seq_ctrl with a behavioural add/sub + 2:1 mux datapath and a product scoreboard.
module tb_booth_seq_ctrl;

  logic i_clk = 1'b0;
  logic i_rst_n;

  always #5 i_clk = ~i_clk;

  booth_seq_ctrl_if bus ();

  booth_seq_ctrl dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  assign bus.i_mux_out = bus.o_mux_sel
                         ? (bus.o_sub ? bus.o_acc - bus.o_mcand_ext : bus.o_acc + bus.o_mcand_ext)
                         : bus.o_acc;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] sb_q[$];
  logic prev_done = 1'b0;

  typedef struct {
    logic signed [3:0] a;
    logic signed [3:0] b;
    logic [7:0]        exp;
    string             name;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_lat(input logic signed [3:0] a, input logic signed [3:0] b);
`ifdef BOOTH_ZERO_SKIP_EN
    if (a == 0 || b == 0) return 1;
`endif
    return 5;
  endfunction

  // scoreboard: every done pulse consumes one expected product
  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if (bus.o_done) begin
        check("done_single_cycle", 32'(prev_done), 32'd0);
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: product %0h with nothing expected at %0t", bus.o_product, $time);
        end else begin
          check("product", 32'(bus.o_product), 32'(sb_q.pop_front()));
        end
      end
      prev_done = bus.o_done;
    end else begin
      prev_done = 1'b0;
    end
  end

  task automatic run_op(input logic signed [3:0] a, input logic signed [3:0] b,
                        input logic [7:0] exp, input string name);
    int  lat;
    bit  seen;
    lat  = 0;
    seen = 0;
    @(negedge i_clk);
    bus.i_mcand  = a;
    bus.i_mplier = b;
    bus.i_start  = 1'b1;
    sb_q.push_back(exp);
    @(posedge i_clk);
    #1 bus.i_start = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge i_clk);
      lat++;
      if (lat == 1) check({name, "_busy"}, 32'(bus.o_busy), 32'd1);
      if (bus.o_done) seen = 1;
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: no done within 20 cycles, expected %0d", name, exp_lat(a, b));
    end else begin
      check({name, "_latency"}, 32'(lat), 32'(exp_lat(a, b)));
    end
  endtask

  initial begin
    vec_t vecs[8];
    bit   seen;

    vecs[0] = '{a: 4'sd3,  b: -4'sd2, exp: 8'hFA, name: "3x-2"};
    vecs[1] = '{a: -4'sd8, b: -4'sd8, exp: 8'h40, name: "-8x-8"};
    vecs[2] = '{a: 4'sd7,  b: -4'sd8, exp: 8'hC8, name: "7x-8"};
    vecs[3] = '{a: 4'sd7,  b: 4'sd7,  exp: 8'h31, name: "7x7"};
    vecs[4] = '{a: 4'sd0,  b: -4'sd5, exp: 8'h00, name: "0x-5"};
    vecs[5] = '{a: -4'sd1, b: -4'sd1, exp: 8'h01, name: "-1x-1"};
    vecs[6] = '{a: -4'sd8, b: 4'sd7,  exp: 8'hC8, name: "-8x7"};
    vecs[7] = '{a: 4'sd5,  b: 4'sd0,  exp: 8'h00, name: "5x0"};

    i_rst_n      = 1'b0;
    bus.i_start  = 1'b0;
    bus.i_mcand  = '0;
    bus.i_mplier = '0;
    repeat (2) @(negedge i_clk);
    check("rst_product", 32'(bus.o_product), 32'd0);
    check("rst_done",    32'(bus.o_done),    32'd0);
    check("rst_busy",    32'(bus.o_busy),    32'd0);
    check("rst_acc",     32'(bus.o_acc),     32'd0);
    check("rst_mcand",   32'(bus.o_mcand_ext), 32'd0);
    i_rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name);
      repeat (2) @(negedge i_clk);
      check({vecs[i].name, "_hold"}, 32'(bus.o_product), 32'(vecs[i].exp));
      check({vecs[i].name, "_idle"}, 32'(bus.o_busy), 32'd0);
    end

    // second start during CALC must be dropped
    @(negedge i_clk);
    bus.i_mcand  = 4'sd3;
    bus.i_mplier = -4'sd2;
    bus.i_start  = 1'b1;
    sb_q.push_back(8'hFA);
    @(posedge i_clk);
    #1 bus.i_start = 1'b0;
    @(negedge i_clk);
    bus.i_mcand  = 4'sd7;
    bus.i_mplier = 4'sd7;
    bus.i_start  = 1'b1;
    @(posedge i_clk);
    #1 bus.i_start = 1'b0;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge i_clk);
      if (bus.o_done) seen = 1;
    end
    check("ignored_start_done_seen", 32'(seen), 32'd1);
    repeat (8) @(negedge i_clk);
    check("ignored_start_no_second", 32'(sb_q.size()), 32'd0);
    check("ignored_start_idle", 32'(bus.o_busy), 32'd0);

    // async reset in the middle of CALC
    @(negedge i_clk);
    bus.i_mcand  = 4'sd3;
    bus.i_mplier = -4'sd2;
    bus.i_start  = 1'b1;
    @(posedge i_clk);
    #1 bus.i_start = 1'b0;
    repeat (2) @(posedge i_clk);
    #2 i_rst_n = 1'b0;
    #1;
    check("midrst_product", 32'(bus.o_product), 32'd0);
    check("midrst_busy",    32'(bus.o_busy),    32'd0);
    check("midrst_done",    32'(bus.o_done),    32'd0);
    check("midrst_acc",     32'(bus.o_acc),     32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    run_op(4'sd5, 4'sd3, 8'h0F, "5x3_after_rst");

    for (int a = -8; a < 8; a++) begin
      for (int b = -8; b < 8; b++) begin
        run_op(4'(a), 4'(b), 8'(a * b), "sweep");
      end
    end

    repeat (3) @(negedge i_clk);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
